// File: rtl/snake_move_controller_if.sv
// Signal bundle between the snake move controller and the game / body datapath.
// The controller attaches through the master modport, the environment through slave.
interface snake_move_controller_if;
  logic [1:0] STATE_IN;
  logic [3:0] PUSH_BUTTONS;
  logic [3:0] SCORE_IN;
  logic       MOVE_ACK;
  logic       MOVE_REQ;
  logic [1:0] MOVE_DIR;
  logic [7:0] MOVES_OUT;

  modport master (
    input  STATE_IN,
    input  PUSH_BUTTONS,
    input  SCORE_IN,
    input  MOVE_ACK,
    output MOVE_REQ,
    output MOVE_DIR,
    output MOVES_OUT
  );

  modport slave (
    output STATE_IN,
    output PUSH_BUTTONS,
    output SCORE_IN,
    output MOVE_ACK,
    input  MOVE_REQ,
    input  MOVE_DIR,
    input  MOVES_OUT
  );
endinterface

// File: rtl/snake_move_controller.sv
// Paces snake moves with a score-dependent tick period, issues one held move request
// per tick, and steers from debounced-edge button presses while refusing reversals.
module snake_move_controller #(
  parameter int CNT_W     = 26,
  parameter int TICK_BASE = 25_000_000,
  parameter int TICK_STEP = 1_500_000,
  parameter int TICK_MIN  = 6_000_000
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  snake_move_controller_if.master bus
);

  localparam int PW = CNT_W + 4;
  localparam logic [PW-1:0]    BASE_W = PW'(TICK_BASE);
  localparam logic [PW-1:0]    STEP_W = PW'(TICK_STEP);
  localparam logic [PW-1:0]    SPAN_W = PW'(TICK_BASE - TICK_MIN);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(TICK_MIN);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [1:0]       PLAY   = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    REQ  = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             req_q, req_d;
  logic [1:0]       dir_q, dir_d;
  logic [7:0]       moves_q, moves_d;
  logic [1:0]       pending_q;

  logic [3:0]       btn_s1, btn_s2, btn_prev;
  logic [3:0]       press;
  logic [1:0]       press_dir;
  logic             press_any;
  logic             press_ok;

  logic [PW-1:0]    step_total;
  logic [CNT_W-1:0] period_now;
  logic             playing;

  // ---------------------------------------------------------------------------
  // Button path: two-flop synchroniser, then a previous-value flop for edge detect.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; a blocking '=' here would collapse the
  // synchroniser chain into a single flop.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
    end else begin
      btn_s1   <= bus.PUSH_BUTTONS;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign press     = btn_s2 & ~btn_prev;
  assign press_any = |press;

  // Lowest set index wins; the rest are dropped even if the winner is refused.
  always_comb begin
    press_dir = 2'b00;
    if      (press[0]) press_dir = 2'b00;
    else if (press[1]) press_dir = 2'b01;
    else if (press[2]) press_dir = 2'b10;
    else if (press[3]) press_dir = 2'b11;
  end

  // A reversal is judged against the last issued move, not the pending one.
  assign press_ok = press_any && ((press_dir ^ 2'b10) != dir_q);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      pending_q <= 2'b01;
    end else if (press_ok) begin
      pending_q <= press_dir;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick period: shrinks with score, clamped at TICK_MIN before any subtraction
  // so it can never underflow.
  // ---------------------------------------------------------------------------
  assign step_total = PW'(bus.SCORE_IN) * STEP_W;
  assign period_now = (step_total >= SPAN_W) ? MIN_C : CNT_W'(BASE_W - step_total);
  assign playing    = (bus.STATE_IN == PLAY);

  // ---------------------------------------------------------------------------
  // Move FSM: next-state and next-register values.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here receives a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    req_d    = req_q;
    dir_d    = dir_q;
    moves_d  = moves_q;

    if (!playing) begin
      // Leaving play aborts any outstanding request without counting it.
      state_d = IDLE;
      count_d = '0;
      req_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = WAIT;
          count_d  = '0;
          period_d = period_now;
        end
        WAIT: begin
          if (count_q == period_q - ONE_C) begin
            state_d = REQ;
            req_d   = 1'b1;
            dir_d   = pending_q;
            count_d = '0;
          end else begin
            count_d = count_q + ONE_C;
          end
        end
        REQ: begin
          if (bus.MOVE_ACK) begin
            state_d  = WAIT;
            req_d    = 1'b0;
            period_d = period_now;
            moves_d  = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= '0;
      req_q    <= 1'b0;
      dir_q    <= 2'b01;
      moves_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      req_q    <= req_d;
      dir_q    <= dir_d;
      moves_q  <= moves_d;
    end
  end

  assign bus.MOVE_REQ  = req_q;
  assign bus.MOVE_DIR  = dir_q;
  assign bus.MOVES_OUT = moves_q;

endmodule

// File: tb/tb_snake_move_controller.sv
// Scoreboard bench for snake_move_controller: expected moves are queued as stimulus
// is applied and checked against each MOVE_REQ rising edge.
module tb_snake_move_controller;

  localparam int CNT_W     = 8;
  localparam int TICK_BASE = 20;
  localparam int TICK_STEP = 2;
  localparam int TICK_MIN  = 6;
  localparam int RISE_BUDGET = 200;

  logic clk = 1'b0;
  logic rst;
  logic tie_ack;
  logic ack_drv;

  always #5 clk = ~clk;

  snake_move_controller_if bus();

  assign bus.MOVE_ACK = tie_ack ? bus.MOVE_REQ : ack_drv;

  snake_move_controller #(
    .CNT_W    (CNT_W),
    .TICK_BASE(TICK_BASE),
    .TICK_STEP(TICK_STEP),
    .TICK_MIN (TICK_MIN)
  ) dut (
    .CLOCK(clk),
    .RESET(rst),
    .bus  (bus.master)
  );

  typedef struct {
    logic [1:0] dir;
    int         gap;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_rise = 0;
  int   model_moves = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic press_btn(input logic [3:0] b);
    bus.PUSH_BUTTONS = b;
    tick();
    bus.PUSH_BUTTONS = 4'b0000;
  endtask

  task automatic push_exp(input logic [1:0] dir, input int gap, input int n);
    exp_t e;
    e.dir = dir;
    e.gap = gap;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  // Pops each expected move and compares it with the next MOVE_REQ rise.
  task automatic drain();
    exp_t e;
    logic prev;
    bit   found;
    int   gap;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      found = 1'b0;
      for (int i = 0; i < RISE_BUDGET && !found; i++) begin
        prev = bus.MOVE_REQ;
        tick();
        if (!prev && bus.MOVE_REQ) found = 1'b1;
      end
      n_cmp++;
      if (!found) begin
        n_err++;
        $display("FAIL req_timeout: no MOVE_REQ rise within %0d cycles, wanted dir %0d", RISE_BUDGET, e.dir);
        continue;
      end
      gap = cyc - last_rise;
      last_rise = cyc;
      n_cmp++;
      if (gap !== e.gap) begin
        n_err++;
        $display("FAIL req_gap: got %0d cycles, expected %0d", gap, e.gap);
      end
      n_cmp++;
      if (bus.MOVE_DIR !== e.dir) begin
        n_err++;
        $display("FAIL req_dir: got %0d, expected %0d", bus.MOVE_DIR, e.dir);
      end
      n_cmp++;
      if (bus.MOVES_OUT !== 8'(model_moves)) begin
        n_err++;
        $display("FAIL req_moves: got %0d, expected %0d", bus.MOVES_OUT, model_moves);
      end
      if (tie_ack && model_moves < 255) model_moves++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.STATE_IN = 2'b00;
    bus.PUSH_BUTTONS = 4'b0000;
    bus.SCORE_IN = 4'd0;
    tie_ack = 1'b1;
    ack_drv = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.MOVE_REQ !== 1'b0) begin
      n_err++;
      $display("FAIL reset_req: got %b, expected 0", bus.MOVE_REQ);
    end
    n_cmp++;
    if (bus.MOVE_DIR !== 2'b01) begin
      n_err++;
      $display("FAIL reset_dir: got %0d, expected 1", bus.MOVE_DIR);
    end
    n_cmp++;
    if (bus.MOVES_OUT !== 8'd0) begin
      n_err++;
      $display("FAIL reset_moves: got %0d, expected 0", bus.MOVES_OUT);
    end
  endtask

  task automatic test_base_period();
    rst = 1'b0;
    bus.STATE_IN = 2'b01;
    last_rise = cyc;
    push_exp(2'b01, TICK_BASE + 1, 3);
    drain();
  endtask

  task automatic test_score();
    bus.SCORE_IN = 4'd7;
    push_exp(2'b01, 7, 2);
    drain();
    bus.SCORE_IN = 4'd8;
    push_exp(2'b01, 7, 1);
    drain();
    bus.SCORE_IN = 4'd10;
    push_exp(2'b01, 7, 1);
    drain();
    bus.SCORE_IN = 4'd15;
    push_exp(2'b01, 7, 1);
    drain();
    bus.SCORE_IN = 4'd3;
    push_exp(2'b01, 15, 1);
    drain();
  endtask

  task automatic test_presses();
    press_btn(4'b1000);
    push_exp(2'b01, 15, 1);
    drain();
    press_btn(4'b0001);
    tick();
    tick();
    press_btn(4'b0100);
    push_exp(2'b10, 15, 1);
    drain();
    press_btn(4'b1000);
    push_exp(2'b11, 15, 1);
    drain();
    press_btn(4'b0101);
    push_exp(2'b00, 15, 1);
    drain();
    press_btn(4'b1100);
    push_exp(2'b00, 15, 1);
    drain();
    press_btn(4'b0010);
    push_exp(2'b01, 15, 1);
    drain();
  endtask

  task automatic test_hold_ack();
    int ack_cyc;
    tick();
    tie_ack = 1'b0;
    ack_drv = 1'b0;
    push_exp(2'b01, 15, 1);
    drain();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({bus.MOVE_REQ, bus.MOVE_DIR, bus.MOVES_OUT} !== {1'b1, 2'b01, 8'(model_moves)}) begin
        n_err++;
        $display("FAIL hold_stable: cycle %0d got req %b dir %0d moves %0d, expected req 1 dir 1 moves %0d",
                 i, bus.MOVE_REQ, bus.MOVE_DIR, bus.MOVES_OUT, model_moves);
      end
    end
    ack_drv = 1'b1;
    tick();
    ack_drv = 1'b0;
    ack_cyc = cyc;
    model_moves++;
    n_cmp++;
    if (bus.MOVE_REQ !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release: got req %b, expected 0", bus.MOVE_REQ);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (bus.MOVES_OUT !== 8'(model_moves)) begin
      n_err++;
      $display("FAIL hold_count_once: got %0d, expected %0d", bus.MOVES_OUT, model_moves);
    end
    last_rise = ack_cyc;
    push_exp(2'b01, TICK_BASE - 3 * TICK_STEP, 1);
    drain();
  endtask

  task automatic test_abort();
    int seen;
    bus.STATE_IN = 2'b11;
    tick();
    n_cmp++;
    if (bus.MOVE_REQ !== 1'b0) begin
      n_err++;
      $display("FAIL abort_req: got %b, expected 0", bus.MOVE_REQ);
    end
    ack_drv = 1'b1;
    tick();
    tick();
    tick();
    ack_drv = 1'b0;
    n_cmp++;
    if (bus.MOVES_OUT !== 8'(model_moves)) begin
      n_err++;
      $display("FAIL abort_moves: got %0d, expected %0d", bus.MOVES_OUT, model_moves);
    end
    n_cmp++;
    if (bus.MOVE_DIR !== 2'b01) begin
      n_err++;
      $display("FAIL abort_dir: got %0d, expected 1", bus.MOVE_DIR);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.MOVE_REQ) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL abort_no_req: got %0d request cycles, expected 0", seen);
    end
  endtask

  task automatic test_saturate_and_reset();
    tie_ack = 1'b1;
    bus.SCORE_IN = 4'd15;
    bus.STATE_IN = 2'b01;
    last_rise = cyc;
    push_exp(2'b01, 7, 300);
    drain();
    tick();
    n_cmp++;
    if (bus.MOVES_OUT !== 8'd255) begin
      n_err++;
      $display("FAIL sat_moves: got %0d, expected 255", bus.MOVES_OUT);
    end
    press_btn(4'b0100);
    push_exp(2'b10, 7, 1);
    drain();
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bus.MOVE_REQ, bus.MOVE_DIR, bus.MOVES_OUT} !== {1'b0, 2'b01, 8'd0}) begin
      n_err++;
      $display("FAIL midwait_reset: got req %b dir %0d moves %0d, expected req 0 dir 1 moves 0",
               bus.MOVE_REQ, bus.MOVE_DIR, bus.MOVES_OUT);
    end
    rst = 1'b0;
    model_moves = 0;
    last_rise = cyc;
    push_exp(2'b01, 7, 1);
    drain();
  endtask

  initial begin
    test_reset();
    test_base_period();
    test_score();
    test_presses();
    test_hold_ack();
    test_abort();
    test_saturate_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
